// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream instruction/operand inputs and the issue packet
// handed to the execute stage, each under its own valid/ready pair.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_operand_a;
  logic [31:0] out_operand_b;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;
  logic        out_illegal;

  // Environment side: supplies instructions and consumes issue packets
  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_alu_op, out_operand_a, out_operand_b,
           out_rd, out_pc, out_illegal
  );

  // Stage side: accepts instructions and produces issue packets
  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_alu_op, out_operand_a, out_operand_b,
           out_rd, out_pc, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes OP / OP-IMM / LUI / AUIPC, selects operands
// and holds one registered issue packet under a valid/ready handshake.
module alu_issue_stage #(
  parameter int CNT_W = 16,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  alu_issue_if.slave       bus,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 mapping shared by OP and OP-IMM (funct7 variants handled by caller)
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  logic            dec_illegal;

  logic            out_valid_reg;
  logic [3:0]      out_op_reg;
  logic [XLEN-1:0] out_a_reg;
  logic [XLEN-1:0] out_b_reg;
  logic [4:0]      out_rd_reg;
  logic [XLEN-1:0] out_pc_reg;
  logic            out_illegal_reg;
  logic [CNT_W-1:0] count_reg;

  logic accept;
  logic handoff;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];

  // A held packet that is being taken this cycle frees the register for a new one
  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign handoff      = out_valid_reg && bus.out_ready;

  // Decode opcode/funct fields into ALU op and operands; illegal forms collapse to zeros
  always_comb begin
    dec_op      = OP_ADD;
    dec_a       = '0;
    dec_b       = '0;
    dec_rd      = bus.in_instr[11:7];
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a = bus.in_rs1_data;
        dec_b = bus.in_rs2_data;
        if (funct7 == F7_ZERO) begin
          dec_op = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_op = OP_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_a  = bus.in_rs1_data;
        dec_b  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        dec_op = base_op(funct3);
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift-immediates: upper immediate bits are the funct7 qualifier
          dec_b = {27'b0, bus.in_instr[24:20]};
          if (funct7 == F7_ZERO) begin
            dec_op = base_op(funct3);
          end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
            dec_op = OP_SRA;
          end else begin
            dec_illegal = 1'b1;
          end
        end
      end
      OPC_LUI: begin
        dec_a = '0;
        dec_b = {bus.in_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec_a = bus.in_pc;
        dec_b = {bus.in_instr[31:12], 12'b0};
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_op = OP_ADD;
      dec_a  = '0;
      dec_b  = '0;
      dec_rd = 5'd0;
    end
  end

  // Output packet register: flush beats accept, accept beats plain handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      out_op_reg      <= '0;
      out_a_reg       <= '0;
      out_b_reg       <= '0;
      out_rd_reg      <= '0;
      out_pc_reg      <= '0;
      out_illegal_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg   <= 1'b1;
      out_op_reg      <= dec_op;
      out_a_reg       <= dec_a;
      out_b_reg       <= dec_b;
      out_rd_reg      <= dec_rd;
      out_pc_reg      <= bus.in_pc;
      out_illegal_reg <= dec_illegal;
    end else if (handoff) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Count packets handed to execute; a flush cycle never counts
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (handoff && !flush) begin
      count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.out_valid     = out_valid_reg;
  assign bus.out_alu_op    = out_op_reg;
  assign bus.out_operand_a = out_a_reg;
  assign bus.out_operand_b = out_b_reg;
  assign bus.out_rd        = out_rd_reg;
  assign bus.out_pc        = out_pc_reg;
  assign bus.out_illegal   = out_illegal_reg;
  assign issue_count       = count_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table, stall/flush/reset
// sequences, and a narrow-counter instance checking wrap-around.
module tb_alu_issue_stage;

  logic clk;
  logic rst;
  logic flush;
  logic [15:0] issue_count;
  logic [1:0]  issue_count2;

  alu_issue_if bus ();
  alu_issue_if bus2 ();

  alu_issue_stage #(.CNT_W(16), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave), .issue_count(issue_count)
  );

  // Second instance with a 2-bit counter follows the same stimulus
  assign bus2.in_valid    = bus.in_valid;
  assign bus2.in_instr    = bus.in_instr;
  assign bus2.in_pc       = bus.in_pc;
  assign bus2.in_rs1_data = bus.in_rs1_data;
  assign bus2.in_rs2_data = bus.in_rs2_data;
  assign bus2.out_ready   = bus.out_ready;

  alu_issue_stage #(.CNT_W(2), .XLEN(32)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus2.slave), .issue_count(issue_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd,
                              input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.ill = ill;
    return v;
  endfunction

  function automatic logic [127:0] act_pkt();
    return {21'b0, bus.out_valid, bus.out_alu_op, bus.out_operand_a, bus.out_operand_b,
            bus.out_rd, bus.out_pc, bus.out_illegal};
  endfunction

  function automatic logic [127:0] exp_pkt(input logic valid, input vec_t v);
    return {21'b0, valid, v.op, v.a, v.b, v.rd, v.pc, v.ill};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.in_valid    = valid;
    bus.in_instr    = v.instr;
    bus.in_pc       = v.pc;
    bus.in_rs1_data = v.rs1;
    bus.in_rs2_data = v.rs2;
  endtask

  vec_t p1, p2, p3, zero_v;

  initial begin
    //            instr         pc            rs1           rs2           op  a             b             rd  ill
    vecs[0]  = mk(32'h002081B3, 32'h00001000, 32'd5,        32'd7,        0,  32'd5,        32'd7,        3,  0); // add
    vecs[1]  = mk(32'h407302B3, 32'h00001004, 32'd20,       32'd9,        1,  32'd20,       32'd9,        5,  0); // sub
    vecs[2]  = mk(32'h40315093, 32'h00001008, 32'h80000000, 32'h0,        7,  32'h80000000, 32'd3,        1,  0); // srai
    vecs[3]  = mk(32'hFFF00093, 32'h0000100C, 32'h0,        32'h0,        0,  32'h0,        32'hFFFFFFFF, 1,  0); // addi -1
    vecs[4]  = mk(32'h12345237, 32'h00000100, 32'hDEAD,     32'hBEEF,     0,  32'h0,        32'h12345000, 4,  0); // lui
    vecs[5]  = mk(32'h00001217, 32'h00000100, 32'hDEAD,     32'hBEEF,     0,  32'h100,      32'h1000,     4,  0); // auipc
    vecs[6]  = mk(32'h0000000B, 32'h00000200, 32'h1234,     32'h5678,     0,  32'h0,        32'h0,        0,  1); // custom opcode
    vecs[7]  = mk(32'h02208133, 32'h00000204, 32'h1,        32'h2,        0,  32'h0,        32'h0,        0,  1); // funct7=0000001
    vecs[8]  = mk(32'h0020B1B3, 32'h00001010, 32'h3,        32'h4,        4,  32'h3,        32'h4,        3,  0); // sltu
    vecs[9]  = mk(32'h0020F1B3, 32'h00001014, 32'hF0F0F0F0, 32'h0FF00FF0, 9,  32'hF0F0F0F0, 32'h0FF00FF0, 3,  0); // and
    vecs[10] = mk(32'h4020D1B3, 32'h00001018, 32'h80000000, 32'h4,        7,  32'h80000000, 32'h4,        3,  0); // sra
    vecs[11] = mk(32'h01F15093, 32'h0000101C, 32'hFFFFFFFF, 32'h0,        6,  32'hFFFFFFFF, 32'd31,       1,  0); // srli 31
    vecs[12] = mk(32'h80014093, 32'h00001020, 32'h55,       32'h0,        5,  32'h55,       32'hFFFFF800, 1,  0); // xori -2048
    vecs[13] = mk(32'h40311093, 32'h00001024, 32'h55,       32'h66,       0,  32'h0,        32'h0,        0,  1); // slli bad funct7

    p1     = mk(32'h002081B3, 32'h40, 32'd1,  32'd2, 0, 32'd1,  32'd2, 3, 0);
    p2     = mk(32'h407302B3, 32'h44, 32'd10, 32'd3, 1, 32'd10, 32'd3, 5, 0);
    p3     = mk(32'h0020F1B3, 32'h48, 32'hF,  32'h3, 9, 32'hF,  32'h3, 3, 0);
    zero_v = mk(32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 0);

    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(zero_v, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("reset_pkt", act_pkt(), exp_pkt(1'b0, zero_v));
    check("reset_count", {112'b0, issue_count}, 128'd0);
    check("reset_in_ready", {127'b0, bus.in_ready}, 128'd1);

    // Decode table, back to back with out_ready=1
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i], 1'b1);
      tick();
      check($sformatf("vec%0d_pkt", i), act_pkt(), exp_pkt(1'b1, vecs[i]));
      check($sformatf("vec%0d_count", i), {112'b0, issue_count}, 128'(i));
    end
    drive(zero_v, 1'b0);
    tick();
    check("drain_valid", {127'b0, bus.out_valid}, 128'd0);
    check("drain_count", {112'b0, issue_count}, 128'(NV));
    check("drain_count2", {126'b0, issue_count2}, 128'(NV % 4));

    // Stall: packet held bit-stable while out_ready=0
    drive(p1, 1'b1);
    tick();
    check("stall_load", act_pkt(), exp_pkt(1'b1, p1));
    drive(p2, 1'b1);
    bus.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d_in_ready", k), {127'b0, bus.in_ready}, 128'd0);
      tick();
      check($sformatf("stall%0d_pkt", k), act_pkt(), exp_pkt(1'b1, p1));
    end
    check("stall_count", {112'b0, issue_count}, 128'(NV));
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", {127'b0, bus.in_ready}, 128'd1);
    tick();
    check("swap_pkt", act_pkt(), exp_pkt(1'b1, p2));
    check("swap_count", {112'b0, issue_count}, 128'(NV + 1));

    // Flush with a held packet, then flush dropping a would-be accept
    bus.out_ready = 1'b0;
    drive(p3, 1'b1);
    flush = 1'b1;
    tick();
    check("flush_held_valid", {127'b0, bus.out_valid}, 128'd0);
    check("flush_held_count", {112'b0, issue_count}, 128'(NV + 1));
    check("flush_in_ready", {127'b0, bus.in_ready}, 128'd1);
    tick();
    check("flush_accept_valid", {127'b0, bus.out_valid}, 128'd0);
    check("flush_accept_count", {112'b0, issue_count}, 128'(NV + 1));
    flush = 1'b0;

    // Reset with a packet held
    drive(p1, 1'b1);
    tick();
    check("pre_rst_pkt", act_pkt(), exp_pkt(1'b1, p1));
    rst = 1'b1;
    drive(p2, 1'b1);
    tick();
    check("rst_pkt", act_pkt(), exp_pkt(1'b0, zero_v));
    check("rst_count", {112'b0, issue_count}, 128'd0);
    check("rst_count2", {126'b0, issue_count2}, 128'd0);
    rst = 1'b0;
    drive(zero_v, 1'b0);
    #1;
    check("post_rst_in_ready", {127'b0, bus.in_ready}, 128'd1);

    // Five handoffs: 2-bit counter wraps to 1
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(vecs[k], 1'b1);
      tick();
    end
    drive(zero_v, 1'b0);
    tick();
    check("wrap_valid", {127'b0, bus.out_valid}, 128'd0);
    check("wrap_count16", {112'b0, issue_count}, 128'd5);
    check("wrap_count2", {126'b0, issue_count2}, 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
